// File: rtl/rr_instr_sequencer.sv
// Control-step sequencer for one register-register instruction: fetch T0-T2,
// execute T3-T5, plus T6 for the two-write HI/LO multiply/divide mode.
module rr_instr_sequencer #(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 16,
  parameter int              REG_W    = 4,
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] MUL_OP   = 5'b01110,
  parameter logic [OP_W-1:0] DIV_OP   = 5'b01111
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mdr_data,
  output logic [NUM_REGS-1:0] rin,
  output logic [NUM_REGS-1:0] rout,
  output logic                pc_out,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                lo_in,
  output logic                hi_in,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // state | meaning
  // IDLE  | waiting for start
  // T0    | PC to MAR, increment PC into Z
  // T1    | memory read, wait for mem_ready, PC <- Z
  // T2    | MDR to IR
  // T3    | first operand into Y
  // T4    | second operand through ALU into Z
  // T5    | write result (normal) or LO (HI/LO mode)
  // T6    | write HI (HI/LO mode only)
  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  localparam int RA_MSB    = DATA_W - 1 - OP_W;
  localparam int RB_MSB    = RA_MSB - REG_W;
  localparam int RC_MSB    = RB_MSB - REG_W;
  localparam int FIELD_LSB = DATA_W - OP_W - 3 * REG_W;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_ir;
  logic [OP_W-1:0]     w_op;
  logic [REG_W-1:0]    w_ra;
  logic [REG_W-1:0]    w_rb;
  logic [REG_W-1:0]    w_rc;
  logic                w_hilo;
  logic [NUM_REGS-1:0] w_oh_ra;
  logic [NUM_REGS-1:0] w_oh_rb;
  logic [NUM_REGS-1:0] w_oh_rc;
  logic                w_err;

  // An out-of-range index simply decodes to an all-zero vector.
  function automatic logic [NUM_REGS-1:0] f_onehot(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign w_op    = r_ir[DATA_W-1 -: OP_W];
  assign w_ra    = r_ir[RA_MSB -: REG_W];
  assign w_rb    = r_ir[RB_MSB -: REG_W];
  assign w_rc    = r_ir[RC_MSB -: REG_W];
  assign w_hilo  = (w_op == MUL_OP) || (w_op == DIV_OP);
  assign w_oh_ra = f_onehot(w_ra);
  assign w_oh_rb = f_onehot(w_rb);
  assign w_oh_rc = f_onehot(w_rc);
  assign w_err   = ~(|w_oh_ra) | ~(|w_oh_rb) | (~w_hilo & ~(|w_oh_rc));

  generate
    if (FIELD_LSB > 0) begin : g_spare_ir
      logic w_unused_ir;
      assign w_unused_ir = ^r_ir[FIELD_LSB-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) r_ir <= mdr_data;
    end
  end

  always_comb begin
    w_next    = r_state;
    rin       = '0;
    rout      = '0;
    pc_out    = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    alu_op    = '0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_T0;
      end
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        // PC is loaded only once, in the cycle the read completes.
        pc_in    = mem_ready;
        if (mem_ready) w_next = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        rout   = w_hilo ? w_oh_ra : w_oh_rb;
        y_in   = 1'b1;
        w_next = S_T4;
      end
      S_T4: begin
        rout   = w_hilo ? w_oh_rb : w_oh_rc;
        z_in   = 1'b1;
        alu_op = w_op;
        w_next = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (w_hilo) begin
          lo_in  = 1'b1;
          w_next = S_T6;
        end else begin
          rin    = w_oh_ra;
          done   = 1'b1;
          err    = w_err;
          w_next = start ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
        err       = w_err;
        w_next    = start ? S_T0 : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_instr_sequencer.sv
// Bench for rr_instr_sequencer: a 16-register and an 8-register instance share
// stimulus and are checked cycle by cycle against a step-schedule model.
module tb_rr_instr_sequencer;

  typedef struct packed {
    logic        busy, done, err;
    logic        pc_out, inc_pc, mar_in, z_in, zlow_out, zhigh_out, pc_in;
    logic        read, mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in;
    logic [4:0]  alu;
    logic [15:0] rin, rout;
  } obs_t;

  typedef struct {
    logic [4:0]  op;
    int          ra, rb, rc, stall;
    logic [15:0] t3, t4, fin;
    int          lat;
    bit          err8;
  } vec_t;

  logic clk = 1'b0;
  logic clr, start, mem_ready;
  logic [31:0] mdr_data;

  logic [15:0] rin16, rout16;
  logic pc_out16, inc_pc16, mar_in16, z_in16, zlow_out16, zhigh_out16, pc_in16;
  logic read16, mdr_in16, mdr_out16, ir_in16, y_in16, lo_in16, hi_in16;
  logic [4:0] alu16;
  logic busy16, done16, err16;

  logic [7:0] rin8, rout8;
  logic pc_out8, inc_pc8, mar_in8, z_in8, zlow_out8, zhigh_out8, pc_in8;
  logic read8, mdr_in8, mdr_out8, ir_in8, y_in8, lo_in8, hi_in8;
  logic [4:0] alu8;
  logic busy8, done8, err8;

  int n_checks = 0;
  int n_err    = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  rr_instr_sequencer u_dut16 (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .mdr_data(mdr_data),
    .rin(rin16), .rout(rout16), .pc_out(pc_out16), .inc_pc(inc_pc16), .mar_in(mar_in16),
    .z_in(z_in16), .zlow_out(zlow_out16), .zhigh_out(zhigh_out16), .pc_in(pc_in16),
    .read(read16), .mdr_in(mdr_in16), .mdr_out(mdr_out16), .ir_in(ir_in16), .y_in(y_in16),
    .lo_in(lo_in16), .hi_in(hi_in16), .alu_op(alu16), .busy(busy16), .done(done16), .err(err16)
  );

  rr_instr_sequencer #(.NUM_REGS(8), .REG_W(4)) u_dut8 (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .mdr_data(mdr_data),
    .rin(rin8), .rout(rout8), .pc_out(pc_out8), .inc_pc(inc_pc8), .mar_in(mar_in8),
    .z_in(z_in8), .zlow_out(zlow_out8), .zhigh_out(zhigh_out8), .pc_in(pc_in8),
    .read(read8), .mdr_in(mdr_in8), .mdr_out(mdr_out8), .ir_in(ir_in8), .y_in(y_in8),
    .lo_in(lo_in8), .hi_in(hi_in8), .alu_op(alu8), .busy(busy8), .done(done8), .err(err8)
  );

  function automatic obs_t obs16();
    obs_t o;
    o = '{busy16, done16, err16, pc_out16, inc_pc16, mar_in16, z_in16, zlow_out16,
          zhigh_out16, pc_in16, read16, mdr_in16, mdr_out16, ir_in16, y_in16, lo_in16,
          hi_in16, alu16, rin16, rout16};
    return o;
  endfunction

  function automatic obs_t obs8();
    obs_t o;
    o = '{busy8, done8, err8, pc_out8, inc_pc8, mar_in8, z_in8, zlow_out8,
          zhigh_out8, pc_in8, read8, mdr_in8, mdr_out8, ir_in8, y_in8, lo_in8,
          hi_in8, alu8, {8'h00, rin8}, {8'h00, rout8}};
    return o;
  endfunction

  function automatic logic [15:0] oh(input int idx, input int nregs);
    return (idx < nregs) ? (16'd1 << idx) : 16'd0;
  endfunction

  // Expected outputs in cycle c after the T0 cycle, from the step rules.
  function automatic obs_t model(input int c, input int stall, input logic [31:0] word,
                                 input int nregs);
    obs_t o;
    logic [4:0] op;
    int ra, rb, rc, e;
    bit hilo;
    o    = '0;
    op   = word[31:27];
    ra   = int'(word[26:23]);
    rb   = int'(word[22:19]);
    rc   = int'(word[18:15]);
    hilo = (op == 5'b01110) || (op == 5'b01111);
    e    = c - stall - 2;
    o.busy = 1'b1;
    if (c == 0) begin
      o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1;
    end else if (e < 0) begin
      o.zlow_out = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
      o.pc_in = (c == stall + 1);
    end else if (e == 0) begin
      o.mdr_out = 1'b1; o.ir_in = 1'b1;
    end else if (e == 1) begin
      o.y_in = 1'b1; o.rout = oh(hilo ? ra : rb, nregs);
    end else if (e == 2) begin
      o.z_in = 1'b1; o.alu = op; o.rout = oh(hilo ? rb : rc, nregs);
    end else if (e == 3) begin
      o.zlow_out = 1'b1;
      if (hilo) o.lo_in = 1'b1;
      else begin o.rin = oh(ra, nregs); o.done = 1'b1; end
    end else if (e == 4 && hilo) begin
      o.zhigh_out = 1'b1; o.hi_in = 1'b1; o.done = 1'b1;
    end
    if (o.done) o.err = (ra >= nregs) || (rb >= nregs) || (!hilo && rc >= nregs);
    return o;
  endfunction

  task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle(input bit st, input string tag);
    @(posedge clk); #1;
    clr       = 1'b0;
    start     = st;
    mem_ready = 1'($urandom_range(0, 1));
    mdr_data  = $urandom;
    #1;
    chk_obs({tag, " idle16"}, obs16(), '0);
    chk_obs({tag, " idle8"}, obs8(), '0);
  endtask

  // Runs one instruction from its T0 cycle; the caller has already presented start.
  task automatic run_instr(input logic [31:0] word, input int stall, input bit next_start,
                           input int abort_c, input string tag,
                           output logic [15:0] t3, output logic [15:0] t4,
                           output logic [15:0] fin, output int lat, output bit e8);
    int len, e;
    obs_t a16, a8;
    bit hilo;
    hilo = (word[31:27] == 5'b01110) || (word[31:27] == 5'b01111);
    len  = stall + (hilo ? 7 : 6);
    t3 = '0; t4 = '0; fin = '0; lat = -1; e8 = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      e = c - stall - 2;
      if (c >= 1 && c <= stall) mem_ready = 1'b0;
      else if (c == stall + 1)  mem_ready = 1'b1;
      else                      mem_ready = 1'($urandom_range(0, 1));
      start    = (c == len - 1) ? next_start : 1'($urandom_range(0, 1));
      mdr_data = (e == 0) ? word : $urandom;
      clr      = (c == abort_c);
      if (c == abort_c) start = 1'b1;
      #1;
      a16 = obs16();
      a8  = obs8();
      if (a16.busy) busy_cnt++;
      chk_obs($sformatf("%s c%0d dut16", tag, c), a16, model(c, stall, word, 16));
      chk_obs($sformatf("%s c%0d dut8", tag, c), a8, model(c, stall, word, 8));
      if (e == 1) t3 = a16.rout;
      if (e == 2) t4 = a16.rout;
      if (a16.done && lat < 0) begin
        lat = c + 1; fin = a16.rin; e8 = a8.err;
      end
      if (c == abort_c) return;
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [4:0] op, input int ra, input int rb,
                                          input int rc);
    logic [14:0] pad;
    pad = 15'($urandom);
    return {op, 4'(ra), 4'(rb), 4'(rc), pad};
  endfunction

  initial begin
    vec_t tbl[6];
    logic [15:0] t3, t4, fin;
    int lat;
    bit e8, chained, nxt;
    logic [31:0] w;
    logic [4:0] op;

    tbl[0] = '{5'b00011, 0, 4, 5, 0, 16'h0010, 16'h0020, 16'h0001, 6, 1'b0};
    tbl[1] = '{5'b00011, 0, 4, 5, 3, 16'h0010, 16'h0020, 16'h0001, 9, 1'b0};
    tbl[2] = '{5'b01110, 2, 3, 0, 0, 16'h0004, 16'h0008, 16'h0000, 7, 1'b0};
    tbl[3] = '{5'b01111, 15, 1, 7, 1, 16'h8000, 16'h0002, 16'h0000, 8, 1'b1};
    tbl[4] = '{5'b10010, 9, 1, 2, 0, 16'h0002, 16'h0004, 16'h0200, 6, 1'b1};
    tbl[5] = '{5'b00111, 14, 15, 0, 0, 16'h8000, 16'h0001, 16'h4000, 6, 1'b1};

    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; mdr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_obs("reset16", obs16(), '0);
    chk_obs("reset8", obs8(), '0);
    idle_cycle(1'b0, "post_reset");

    for (int i = 0; i < 6; i++) begin
      string tg;
      tg = $sformatf("vec%0d", i);
      idle_cycle(1'b1, tg);
      run_instr(mk_word(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rc), tbl[i].stall, 1'b0, -1,
                tg, t3, t4, fin, lat, e8);
      chk_int({tg, " t3_rout"}, int'(t3), int'(tbl[i].t3));
      chk_int({tg, " t4_rout"}, int'(t4), int'(tbl[i].t4));
      chk_int({tg, " final_rin"}, int'(fin), int'(tbl[i].fin));
      chk_int({tg, " latency"}, lat, tbl[i].lat);
      chk_int({tg, " err8"}, int'(e8), int'(tbl[i].err8));
    end
    idle_cycle(1'b0, "after_tbl");

    // Back-to-back: two adds with start held, busy must stay high for 12 cycles.
    idle_cycle(1'b1, "b2b");
    busy_cnt = 0;
    run_instr(mk_word(5'b00011, 0, 4, 5), 0, 1'b1, -1, "b2b_a", t3, t4, fin, lat, e8);
    run_instr(mk_word(5'b00100, 1, 2, 3), 0, 1'b0, -1, "b2b_b", t3, t4, fin, lat, e8);
    idle_cycle(1'b0, "b2b_end");
    chk_int("b2b busy_cycles", busy_cnt, 12);

    // Reset in T4 with start also high: must land in IDLE and stay there.
    idle_cycle(1'b1, "abort");
    run_instr(mk_word(5'b00011, 0, 4, 5), 0, 1'b0, 4, "abort", t3, t4, fin, lat, e8);
    idle_cycle(1'b0, "abort_r1");
    idle_cycle(1'b0, "abort_r2");

    chained = 1'b0;
    for (int k = 0; k < 30; k++) begin
      string tg;
      tg = $sformatf("rnd%0d", k);
      case ($urandom_range(0, 5))
        0:       op = 5'b01110;
        1:       op = 5'b01111;
        default: op = 5'($urandom);
      endcase
      w   = mk_word(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      nxt = (k != 29) && ($urandom_range(0, 1) == 1);
      if (!chained) idle_cycle(1'b1, tg);
      run_instr(w, $urandom_range(0, 3), nxt, -1, tg, t3, t4, fin, lat, e8);
      chained = nxt;
    end
    idle_cycle(1'b0, "final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
